aib_prbs_rx_chk: RTL and testbench

Per-channel DV receive checker that sits directly downstream of an EMIB channel model. It samples the receive data pins of one AIB channel after the EMIB connection and self-seeds a PRBS7 or PRBS31 predictor from that data. Once seeded, it locks and counts word and bit errors. One instance per channel lets a bench score 24-channel link integrity without a golden transmit reference.

---
 rtl/aib_prbs_rx_chk_if.sv | 27 ++
 rtl/aib_prbs_rx_chk.sv | 146 ++++++++++++++
 tb/tb_aib_prbs_rx_chk.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/aib_prbs_rx_chk_if.sv
// Signal bundle between a bench and one AIB PRBS receive checker:
// the sampled channel data and controls in, the lock status and error counters out.
interface aib_prbs_rx_chk_if #(
    parameter int DWIDTH = 40
);
    logic              i_en;
    logic              i_prbs_sel;
    logic              i_valid;
    logic [DWIDTH-1:0] i_data;
    logic              i_clr;
    logic [1:0]        o_state;
    logic              o_locked;
    logic              o_err;
    logic [31:0]       o_word_cnt;
    logic [31:0]       o_err_cnt;
    logic [31:0]       o_bit_err_cnt;

    modport master (
        output i_en, i_prbs_sel, i_valid, i_data, i_clr,
        input  o_state, o_locked, o_err, o_word_cnt, o_err_cnt, o_bit_err_cnt
    );

    modport slave (
        input  i_en, i_prbs_sel, i_valid, i_data, i_clr,
        output o_state, o_locked, o_err, o_word_cnt, o_err_cnt, o_bit_err_cnt
    );
endinterface

// File: rtl/aib_prbs_rx_chk.sv
// Self-seeding PRBS7/PRBS31 receive checker for one AIB channel: locks onto the
// incoming stream and then counts words, errored words and errored bits.
module aib_prbs_rx_chk #(
    parameter int DWIDTH   = 40,
    parameter int LOCK_CNT = 16,
    parameter int ERR_LOSS = 4
) (
    input logic               clk,
    input logic               rst_n,
    aib_prbs_rx_chk_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3} state_t;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_LOSS + 1);
    localparam logic [MW-1:0] LAST_MATCH = MW'(LOCK_CNT - 1);
    localparam logic [EW-1:0] LAST_ERR   = EW'(ERR_LOSS - 1);

    // Extends the sequence one word past ref_word; bit 0 is the earliest bit.
    function automatic logic [DWIDTH-1:0] prbs_next(input logic [DWIDTH-1:0] ref_word,
                                                    input logic sel);
        logic [2*DWIDTH-1:0] ext;
        ext = {{DWIDTH{1'b0}}, ref_word};
        for (int k = DWIDTH; k < 2*DWIDTH; k++)
            ext[k] = sel ? (ext[k-31] ^ ext[k-28]) : (ext[k-7] ^ ext[k-6]);
        return ext[2*DWIDTH-1:DWIDTH];
    endfunction

    function automatic logic [31:0] popcount(input logic [DWIDTH-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int k = 0; k < DWIDTH; k++)
            c = c + 32'(v[k]);
        return c;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    state_t            state_p1, state_d;
    logic [MW-1:0]     match_p1, match_d;
    logic [EW-1:0]     run_p1, run_d;
    logic [DWIDTH-1:0] ref_p1, ref_d;
    logic              locked_p1, err_p1;
    logic [31:0]       word_cnt_p1, err_cnt_p1, bit_err_cnt_p1;

    logic [DWIDTH-1:0] expected;
    logic              adv, hit, locked_word;

    assign expected    = prbs_next(ref_p1, bus.i_prbs_sel);
    assign adv         = bus.i_valid;
    assign hit         = (bus.i_data == expected);
    assign locked_word = bus.i_en && adv && (state_p1 == LOCKED);

    always_comb begin
        state_d = state_p1;
        match_d = match_p1;
        run_d   = run_p1;
        ref_d   = ref_p1;
        if (!bus.i_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_p1)
                IDLE: begin
                    state_d = SEED;
                    match_d = '0;
                    run_d   = '0;
                end
                SEED: if (adv) begin
                    ref_d   = bus.i_data;
                    match_d = '0;
                    state_d = VERIFY;
                end
                VERIFY: if (adv) begin
                    ref_d = bus.i_data;
                    if (hit) begin
                        match_d = match_p1 + MW'(1);
                        if (match_p1 == LAST_MATCH) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: if (adv) begin
                    // Free-run on the prediction so a bad word cannot corrupt the next one.
                    ref_d = expected;
                    if (hit) begin
                        run_d = '0;
                    end else begin
                        run_d = run_p1 + EW'(1);
                        if (run_p1 == LAST_ERR) begin
                            state_d = SEED;
                            run_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 1: FSM, predictor reference and counters all register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1       <= IDLE;
            match_p1       <= '0;
            run_p1         <= '0;
            ref_p1         <= '0;
            locked_p1      <= 1'b0;
            err_p1         <= 1'b0;
            word_cnt_p1    <= '0;
            err_cnt_p1     <= '0;
            bit_err_cnt_p1 <= '0;
        end else begin
            state_p1  <= state_d;
            match_p1  <= match_d;
            run_p1    <= run_d;
            ref_p1    <= ref_d;
            locked_p1 <= (state_d == LOCKED);
            err_p1    <= locked_word && !hit;
            if (bus.i_clr) begin
                word_cnt_p1    <= '0;
                err_cnt_p1     <= '0;
                bit_err_cnt_p1 <= '0;
            end else if (locked_word) begin
                word_cnt_p1 <= sat_add(word_cnt_p1, 32'd1);
                if (!hit) begin
                    err_cnt_p1     <= sat_add(err_cnt_p1, 32'd1);
                    bit_err_cnt_p1 <= sat_add(bit_err_cnt_p1, popcount(bus.i_data ^ expected));
                end
            end
        end
    end

    assign bus.o_state       = state_p1;
    assign bus.o_locked      = locked_p1;
    assign bus.o_err         = err_p1;
    assign bus.o_word_cnt    = word_cnt_p1;
    assign bus.o_err_cnt     = err_cnt_p1;
    assign bus.o_bit_err_cnt = bit_err_cnt_p1;
endmodule

// File: tb/tb_aib_prbs_rx_chk.sv
// Directed bench for aib_prbs_rx_chk: lock, single and burst errors, gapped PRBS7,
// clear-versus-error priority and asynchronous reset with the clock stopped.
module tb_aib_prbs_rx_chk;
    localparam int DW = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_run = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    logic [30:0] hist;
    logic        gen_sel;

    aib_prbs_rx_chk_if #(.DWIDTH(DW)) bus ();

    aib_prbs_rx_chk #(.DWIDTH(DW), .LOCK_CNT(16), .ERR_LOSS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference LFSR; hist[0] is the most recent bit.
    task automatic next_word(output logic [DW-1:0] w);
        logic b;
        for (int k = 0; k < DW; k++) begin
            b    = gen_sel ? (hist[30] ^ hist[27]) : (hist[6] ^ hist[5]);
            w[k] = b;
            hist = {hist[29:0], b};
        end
    endtask

    task automatic send(input logic [DW-1:0] flip);
        logic [DW-1:0] w;
        next_word(w);
        bus.i_valid = 1'b1;
        bus.i_data  = w ^ flip;
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send('0);
    endtask

    task automatic gap();
        bus.i_valid = 1'b0;
        bus.i_data  = {8'hA5, $urandom()};
        tick();
    endtask

    initial begin
        bus.i_en = 1'b0; bus.i_prbs_sel = 1'b1; bus.i_valid = 1'b0;
        bus.i_data = '0; bus.i_clr = 1'b0;
        gen_sel = 1'b1; hist = 31'h2A5C_3F17;

        tick(); tick();
        chk("rst_state", 64'(bus.o_state), 64'd0);
        chk("rst_locked", 64'(bus.o_locked), 64'd0);
        chk("rst_err", 64'(bus.o_err), 64'd0);
        chk("rst_word_cnt", 64'(bus.o_word_cnt), 64'd0);
        chk("rst_bit_err_cnt", 64'(bus.o_bit_err_cnt), 64'd0);
        rst_n = 1'b1;

        // Clean PRBS31 lock and run.
        bus.i_en = 1'b1;
        tick();
        chk("seed_state", 64'(bus.o_state), 64'd1);
        send_clean(1);
        chk("verify_state", 64'(bus.o_state), 64'd2);
        send_clean(15);
        chk("p31_not_locked_16", 64'(bus.o_locked), 64'd0);
        send_clean(1);
        chk("p31_locked_17", 64'(bus.o_locked), 64'd1);
        chk("p31_state_locked", 64'(bus.o_state), 64'd3);
        send_clean(1000);
        chk("p31_word_cnt_1000", 64'(bus.o_word_cnt), 64'd1000);
        chk("p31_err_cnt_0", 64'(bus.o_err_cnt), 64'd0);
        chk("p31_bit_err_0", 64'(bus.o_bit_err_cnt), 64'd0);

        // Three flipped bits in one word.
        send(40'h80_0001_0004);
        chk("flip3_err_pulse", 64'(bus.o_err), 64'd1);
        chk("flip3_err_cnt", 64'(bus.o_err_cnt), 64'd1);
        chk("flip3_bit_err", 64'(bus.o_bit_err_cnt), 64'd3);
        chk("flip3_locked", 64'(bus.o_locked), 64'd1);
        send_clean(1);
        chk("flip3_next_clean", 64'(bus.o_err), 64'd0);
        chk("flip3_err_cnt_hold", 64'(bus.o_err_cnt), 64'd1);
        chk("flip3_word_cnt", 64'(bus.o_word_cnt), 64'd1002);

        // Four consecutive errored words drop lock.
        bus.i_clr = 1'b1;
        tick();
        bus.i_clr = 1'b0;
        chk("clr_word_cnt", 64'(bus.o_word_cnt), 64'd0);
        chk("clr_err_cnt", 64'(bus.o_err_cnt), 64'd0);
        for (int i = 0; i < 3; i++) send(40'h1);
        chk("burst3_locked", 64'(bus.o_locked), 64'd1);
        chk("burst3_err_cnt", 64'(bus.o_err_cnt), 64'd3);
        send(40'h1);
        chk("burst4_err_cnt", 64'(bus.o_err_cnt), 64'd4);
        chk("burst4_bit_err", 64'(bus.o_bit_err_cnt), 64'd4);
        chk("burst4_unlocked", 64'(bus.o_locked), 64'd0);
        chk("burst4_state_seed", 64'(bus.o_state), 64'd1);
        send_clean(1);
        chk("relock_state_verify", 64'(bus.o_state), 64'd2);
        send_clean(15);
        chk("relock_not_yet", 64'(bus.o_locked), 64'd0);
        send_clean(1);
        chk("relock_locked", 64'(bus.o_locked), 64'd1);
        chk("relock_word_cnt_held", 64'(bus.o_word_cnt), 64'd4);

        // Clear coinciding with an errored word.
        bus.i_clr = 1'b1;
        send(40'h10_0000_0000);
        bus.i_clr = 1'b0;
        chk("clr_err_pulse", 64'(bus.o_err), 64'd1);
        chk("clr_err_cnt_zero", 64'(bus.o_err_cnt), 64'd0);
        chk("clr_bit_err_zero", 64'(bus.o_bit_err_cnt), 64'd0);
        chk("clr_word_cnt_zero", 64'(bus.o_word_cnt), 64'd0);
        send_clean(1);
        chk("clr_after_err_low", 64'(bus.o_err), 64'd0);
        chk("clr_after_word_cnt", 64'(bus.o_word_cnt), 64'd1);

        // Gapped PRBS7 stream.
        bus.i_en = 1'b0;
        tick();
        chk("en_low_idle", 64'(bus.o_state), 64'd0);
        bus.i_prbs_sel = 1'b0; gen_sel = 1'b0; hist = 31'h45;
        bus.i_clr = 1'b1;
        tick();
        bus.i_clr = 1'b0;
        bus.i_en = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin send_clean(1); gap(); end
        chk("p7_not_locked_16", 64'(bus.o_locked), 64'd0);
        send_clean(1);
        chk("p7_locked_17", 64'(bus.o_locked), 64'd1);
        gap();
        chk("p7_gap_locked", 64'(bus.o_locked), 64'd1);
        for (int i = 0; i < 4; i++) begin send_clean(1); gap(); end
        chk("p7_word_cnt", 64'(bus.o_word_cnt), 64'd4);
        chk("p7_err_cnt", 64'(bus.o_err_cnt), 64'd0);

        // Asynchronous reset with the clock stopped.
        clk_run = 1'b0;
        #3;
        rst_n = 1'b0;
        #2;
        chk("arst_locked", 64'(bus.o_locked), 64'd0);
        chk("arst_state", 64'(bus.o_state), 64'd0);
        chk("arst_word_cnt", 64'(bus.o_word_cnt), 64'd0);
        chk("arst_err_cnt", 64'(bus.o_err_cnt), 64'd0);
        chk("arst_bit_err_cnt", 64'(bus.o_bit_err_cnt), 64'd0);
        bus.i_en = 1'b0; bus.i_prbs_sel = 1'b1; gen_sel = 1'b1; hist = 31'h1357_9BDF;
        #5;
        rst_n = 1'b1;
        clk_run = 1'b1;
        bus.i_en = 1'b1;
        tick();
        send_clean(17);
        chk("arst_relock", 64'(bus.o_locked), 64'd1);
        chk("arst_relock_state", 64'(bus.o_state), 64'd3);
        send_clean(5);
        chk("arst_relock_word_cnt", 64'(bus.o_word_cnt), 64'd5);
        chk("arst_relock_err_cnt", 64'(bus.o_err_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
